api_spi_engine: RTL

//  Parametrised next-generation API shift engine: pops words from the TX FIFO, broadcasts them MSB-first on mosi,

---
 rtl/api_pkg.sv | 20 ++
 rtl/api_sck_gen.sv | 37 +++
 rtl/api_spi_engine.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/api_pkg.sv
// Shared constants for the API shift engine: FSM encodings, channel tag width, popcount helper.
package api_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SHIFT = 3'd1;
    localparam logic [2:0] ST_STORE = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;

    localparam int unsigned CH_IDX_W = 5;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/api_sck_gen.sv
// Serial clock divider: sck half-period = div+1 clocks, idles low whenever en is low.
module api_sck_gen (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       en,
    input  logic [7:0] div,
    output logic       sck,
    output logic       sck_rise,
    output logic       sck_fall
);

    logic [7:0] cnt_q;
    logic       sck_q;
    logic       tick;

    assign tick     = en && (cnt_q == div);
    // Strobes flag the edge at which the registered sck is about to toggle.
    assign sck_rise = tick && !sck_q;
    assign sck_fall = tick && sck_q;
    assign sck      = sck_q;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            cnt_q <= 8'd0;
            sck_q <= 1'b0;
        end else if (!en) begin
            cnt_q <= 8'd0;
            sck_q <= 1'b0;
        end else if (tick) begin
            cnt_q <= 8'd0;
            sck_q <= ~sck_q;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/api_spi_engine.sv
// API shift engine: TX FIFO words out on mosi, per-channel miso capture drained to RX FIFO.
// Optional sticky round-done interrupt when API_IRQ_EN is defined.
module api_spi_engine
    import api_pkg::*;
#(
    parameter int unsigned CH_NUM = 8,
    parameter int unsigned DW     = 32,
    parameter int unsigned CNT_W  = 10
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              start,
    input  logic [7:0]        cfg_sck_div,
    input  logic [7:0]        cfg_word_num,
    input  logic [CH_NUM-1:0] cfg_ch_mask,
    input  logic [27:0]       cfg_gap,
    input  logic [CNT_W-1:0]  tx_count,
    output logic              tx_rd_en,
    input  logic [DW-1:0]     tx_dout,
    input  logic [CNT_W-1:0]  rx_free,
    output logic              rx_wr_en,
    output logic [DW+4:0]     rx_din,
    output logic [CH_NUM-1:0] load,
    output logic              sck,
    output logic              mosi,
    input  logic [CH_NUM-1:0] miso,
`ifdef API_IRQ_EN
    output logic              irq,
`endif
    output logic [2:0]        state
);

    logic [2:0]          state_q, state_d;
    logic [7:0]          div_q, word_rem_q;
    logic [CH_NUM-1:0]   mask_q, pend_q, pend_nxt;
    logic [27:0]         gap_q, gap_cnt_q;
    logic [5:0]          bit_cnt_q;
    logic [DW-1:0]       tx_sr_q;
    logic [DW-1:0]       rx_sr_q [CH_NUM];
    logic                tx_rd_en_q, rx_wr_en_q;
    logic [DW+4:0]       rx_din_q;
    logic                sck_rise, sck_fall;
    logic                admit, found, store_done, word_end;
    logic [CH_IDX_W-1:0] pick_idx;
    logic [DW-1:0]       pick_data;

    api_sck_gen u_sck_gen (
        .CLK_I    (CLK_I),
        .RST_I    (RST_I),
        .en       (state_q == ST_SHIFT),
        .div      (div_q),
        .sck      (sck),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall)
    );

    // RX admission covers the whole round so the RX FIFO can never overflow.
    assign admit = start && (cfg_word_num != 8'd0) &&
                   (32'(tx_count) >= 32'(cfg_word_num)) &&
                   (32'(rx_free) >= popcount(32'(cfg_ch_mask)) * 32'(cfg_word_num));

    assign word_end = sck_fall && (bit_cnt_q == 6'(DW - 1));

    // Lowest pending channel is drained this cycle; disabled channels never enter pend.
    always_comb begin
        found     = 1'b0;
        pick_idx  = '0;
        pick_data = '0;
        pend_nxt  = pend_q;
        for (int c = 0; c < CH_NUM; c++) begin
            if (pend_q[c] && !found) begin
                found       = 1'b1;
                pick_idx    = CH_IDX_W'(c);
                pick_data   = rx_sr_q[c];
                pend_nxt[c] = 1'b0;
            end
        end
        store_done = (pend_nxt == '0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (admit) state_d = ST_SHIFT;
            ST_SHIFT: if (word_end) state_d = ST_STORE;
            ST_STORE: if (store_done) state_d = (word_rem_q != 8'd0) ? ST_SHIFT : ST_GAP;
            ST_GAP:   if (gap_cnt_q <= 28'd1) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q    <= ST_IDLE;
            div_q      <= 8'd0;
            word_rem_q <= 8'd0;
            mask_q     <= '0;
            pend_q     <= '0;
            gap_q      <= 28'd0;
            gap_cnt_q  <= 28'd0;
            bit_cnt_q  <= 6'd0;
            tx_sr_q    <= '0;
            tx_rd_en_q <= 1'b0;
            rx_wr_en_q <= 1'b0;
            rx_din_q   <= '0;
            for (int c = 0; c < CH_NUM; c++) rx_sr_q[c] <= '0;
        end else begin
            state_q    <= state_d;
            tx_rd_en_q <= 1'b0;
            rx_wr_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (admit) begin
                        div_q      <= cfg_sck_div;
                        word_rem_q <= cfg_word_num - 8'd1;
                        mask_q     <= cfg_ch_mask;
                        gap_q      <= cfg_gap;
                        // FWFT head captured now, popped on the following cycle.
                        tx_sr_q    <= tx_dout;
                        tx_rd_en_q <= 1'b1;
                        bit_cnt_q  <= 6'd0;
                    end
                end
                ST_SHIFT: begin
                    if (sck_rise) begin
                        for (int c = 0; c < CH_NUM; c++) begin
                            rx_sr_q[c] <= {rx_sr_q[c][DW-2:0], miso[c]};
                        end
                    end
                    if (sck_fall) begin
                        tx_sr_q   <= tx_sr_q << 1;
                        bit_cnt_q <= bit_cnt_q + 6'd1;
                    end
                    if (word_end) pend_q <= mask_q;
                end
                ST_STORE: begin
                    if (found) begin
                        rx_wr_en_q <= 1'b1;
                        rx_din_q   <= {pick_idx, pick_data};
                    end
                    pend_q <= pend_nxt;
                    if (store_done) begin
                        if (word_rem_q != 8'd0) begin
                            word_rem_q <= word_rem_q - 8'd1;
                            tx_sr_q    <= tx_dout;
                            tx_rd_en_q <= 1'b1;
                            bit_cnt_q  <= 6'd0;
                        end else begin
                            gap_cnt_q  <= gap_q;
                        end
                    end
                end
                ST_GAP: gap_cnt_q <= gap_cnt_q - 28'd1;
                default: ;
            endcase
        end
    end

`ifdef API_IRQ_EN
    logic irq_q, start_q;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            irq_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            start_q <= start;
            if (state_q == ST_STORE && state_d == ST_GAP) irq_q <= 1'b1;
            else if (start && !start_q)                   irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`endif

    assign state    = state_q;
    assign tx_rd_en = tx_rd_en_q;
    assign rx_wr_en = rx_wr_en_q;
    assign rx_din   = rx_din_q;
    assign load     = (state_q == ST_SHIFT || state_q == ST_STORE) ? mask_q : '0;
    assign mosi     = (state_q == ST_SHIFT) & tx_sr_q[DW-1];

endmodule
